// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants, types and helpers for the scoreboarded register file.
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width / address width
//   - reg_addr_t                      : register address at the default width
//   - addr_in_range()                 : true when an address selects a physical
//                                       register (NUM_REGS may be smaller than
//                                       the address space)
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   One pending-write bit per register. An issue marks its destination busy,
//   a write-back clears it; when both hit the same register in one cycle the
//   issue wins, because that register now waits on the newer instruction.
//   There is no counting: a second issue to a busy register leaves it busy.
//   Addresses >= NUM_REGS are ignored.
//
// Ports
//   clk          in   clock, updates on posedge
//   reset        in   asynchronous active-high reset, clears all busy bits
//   issue_valid  in   mark issue_reg pending
//   issue_reg    in   destination of the issued instruction
//   wb_valid     in   write-back strobe, clears wb_reg
//   wb_reg       in   write-back destination
//   busy_vec     out  registered busy bits, bit i = register i pending
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_REGS = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_reg,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_reg,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_nxt;

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && addr_in_range(32'(issue_reg), NUM_REGS))
            set_mask[index_of(issue_reg)] = 1'b1;
        if (wb_valid && addr_in_range(32'(wb_reg), NUM_REGS))
            clr_mask[index_of(wb_reg)] = 1'b1;
        // Clear first, then set: a same-register issue overrides the clear.
        busy_nxt = (busy_vec & ~clr_mask) | set_mask;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_vec <= '0;
        else
            busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//   Register file with two registered read ports, one write-back port and a
//   pending-write scoreboard for read-after-write hazard detection.
//   Read data and ready appear one cycle after the address is presented.
//   Addresses >= NUM_REGS read as 0 / ready and are never written.
//
// Configuration macro
//   REGFILE_BYPASS_EN  defined   : a read of the register being written back
//                                  in the same cycle returns wb_data; ready is
//                                  1 unless an issue to that register happens
//                                  in the same cycle.
//                      undefined : reads see storage and busy state as they
//                                  were before the edge; the new value shows
//                                  up one cycle later.
//
// Parameters
//   DATA_W, ADDR_W, NUM_REGS (NUM_REGS must not exceed 2**ADDR_W)
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   rd_addr1 / rd_addr2     read addresses, sampled on posedge
//   rd_data1 / rd_data2     registered read data
//   rd_ready1 / rd_ready2   registered, 1 = register not pending a write
//   issue_valid, issue_reg  mark a destination register pending
//   wb_valid, wb_reg,       write-back strobe, destination and data
//   wb_data
//   busy_vec                live scoreboard bits
//   last_wb                 data of the most recent write-back (debug)
// ----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_REGS = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_ready1,
    output logic                rd_ready2,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_reg,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [DATA_W-1:0]   last_wb
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wb_hit;

    logic [ADDR_W-1:0] rd_addr     [2];
    logic [DATA_W-1:0] rd_data_nxt [2];
    logic              rd_ready_nxt[2];

    assign wb_hit     = wb_valid && addr_in_range(32'(wb_reg), NUM_REGS);
    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .busy_vec    (busy_vec)
    );

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array is reset because architectural registers must read 0
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else if (wb_hit) begin
            mem[index_of(wb_reg)] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Read muxes (next-state of the registered read ports)
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_nxt[p]  = '0;
            rd_ready_nxt[p] = 1'b1;
            if (addr_in_range(32'(rd_addr[p]), NUM_REGS)) begin
                rd_data_nxt[p]  = mem[index_of(rd_addr[p])];
                rd_ready_nxt[p] = ~busy_vec[index_of(rd_addr[p])];
`ifdef REGFILE_BYPASS_EN
                // Forward the write-back; it only resolves the hazard if no
                // newer instruction re-claims the register in this cycle.
                if (wb_hit && rd_addr[p] == wb_reg) begin
                    rd_data_nxt[p]  = wb_data;
                    rd_ready_nxt[p] = ~(issue_valid && issue_reg == wb_reg);
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1  <= '0;
            rd_data2  <= '0;
            rd_ready1 <= 1'b1;
            rd_ready2 <= 1'b1;
            last_wb   <= '0;
        end else begin
            rd_data1  <= rd_data_nxt[0];
            rd_data2  <= rd_data_nxt[1];
            rd_ready1 <= rd_ready_nxt[0];
            rd_ready2 <= rd_ready_nxt[1];
            // Tracks every strobe, including ones to unmapped addresses.
            if (wb_valid)
                last_wb <= wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//   Directed bench for regfile_sb. A default instance (16 registers) runs a
//   table of per-cycle vectors; a NUM_REGS=8 instance shares the inputs and is
//   checked for unmapped-address handling. Expectations follow the
//   REGFILE_BYPASS_EN setting of the build.
// ----------------------------------------------------------------------------
module tb_regfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    reg_addr_t   rd_addr1, rd_addr2, issue_reg, wb_reg;
    logic        issue_valid, wb_valid;
    logic [15:0] wb_data;

    logic [15:0] rd_data1, rd_data2, last_wb;
    logic        rd_ready1, rd_ready2;
    logic [15:0] busy_vec;

    logic [15:0] rd_data1_8, rd_data2_8, last_wb_8;
    logic        rd_ready1_8, rd_ready2_8;
    logic [7:0]  busy_vec_8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .rd_ready1   (rd_ready1),
        .rd_ready2   (rd_ready2),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec),
        .last_wb     (last_wb)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1_8),
        .rd_data2    (rd_data2_8),
        .rd_ready1   (rd_ready1_8),
        .rd_ready2   (rd_ready2_8),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec_8),
        .last_wb     (last_wb_8)
    );

    typedef struct {
        logic        iv;
        reg_addr_t   ir;
        logic        wv;
        reg_addr_t   wr;
        logic [15:0] wd;
        reg_addr_t   a1;
        reg_addr_t   a2;
        logic [15:0] d1;
        logic        r1;
        logic [15:0] d2;
        logic        r2;
        logic [15:0] busy;
        logic [15:0] lwb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input reg_addr_t ir, input logic wv,
                         input reg_addr_t wr, input logic [15:0] wd,
                         input reg_addr_t a1, input reg_addr_t a2);
        issue_valid = iv;
        issue_reg   = ir;
        wb_valid    = wv;
        wb_reg      = wr;
        wb_data     = wd;
        rd_addr1    = a1;
        rd_addr2    = a2;
    endtask

    initial begin
        //            iv ir  wv wr  wd        a1 a2  d1                        r1                d2                        r2                busy      lwb
        vecs.push_back('{0, 0, 1, 3, 16'hBEEF, 0, 0, 16'h0000,                 1'b1,             16'h0000,                 1'b1,             16'h0000, 16'hBEEF});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 3, 3, 16'hBEEF,                 1'b1,             16'hBEEF,                 1'b1,             16'h0000, 16'hBEEF});
        vecs.push_back('{1, 5, 0, 0, 16'h0000, 3, 3, 16'hBEEF,                 1'b1,             16'hBEEF,                 1'b1,             16'h0020, 16'hBEEF});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 5, 5, 16'h0000,                 1'b0,             16'h0000,                 1'b0,             16'h0020, 16'hBEEF});
        vecs.push_back('{0, 0, 1, 5, 16'h1234, 5, 3, BYP ? 16'h1234 : 16'h0,   BYP,              16'hBEEF,                 1'b1,             16'h0000, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 5, 5, 16'h1234,                 1'b1,             16'h1234,                 1'b1,             16'h0000, 16'h1234});
        vecs.push_back('{0, 0, 1, 7, 16'h0011, 0, 0, 16'h0000,                 1'b1,             16'h0000,                 1'b1,             16'h0000, 16'h0011});
        vecs.push_back('{0, 0, 1, 7, 16'h00AA, 7, 7, BYP ? 16'h00AA : 16'h0011, 1'b1,            BYP ? 16'h00AA : 16'h0011, 1'b1,            16'h0000, 16'h00AA});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 7, 7, 16'h00AA,                 1'b1,             16'h00AA,                 1'b1,             16'h0000, 16'h00AA});
        vecs.push_back('{1, 9, 1, 9, 16'h5555, 9, 9, BYP ? 16'h5555 : 16'h0,   !BYP,             BYP ? 16'h5555 : 16'h0,   !BYP,             16'h0200, 16'h5555});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 9, 9, 16'h5555,                 1'b0,             16'h5555,                 1'b0,             16'h0200, 16'h5555});
        vecs.push_back('{1, 9, 0, 0, 16'h0000, 9, 9, 16'h5555,                 1'b0,             16'h5555,                 1'b0,             16'h0200, 16'h5555});
        vecs.push_back('{1, 4, 1, 2, 16'h0F0F, 1, 2, 16'h0000,                 1'b1,             BYP ? 16'h0F0F : 16'h0,   1'b1,             16'h0210, 16'h0F0F});
        vecs.push_back('{0, 0, 1,12, 16'hCAFE,12,12, BYP ? 16'hCAFE : 16'h0,   1'b1,             BYP ? 16'hCAFE : 16'h0,   1'b1,             16'h0210, 16'hCAFE});
        vecs.push_back('{0, 0, 0, 0, 16'h0000,12,12, 16'hCAFE,                 1'b1,             16'hCAFE,                 1'b1,             16'h0210, 16'hCAFE});
        vecs.push_back('{0, 0, 1, 4, 16'h4444, 4, 4, BYP ? 16'h4444 : 16'h0,   BYP,              BYP ? 16'h4444 : 16'h0,   BYP,              16'h0200, 16'h4444});

        // Initial reset, released away from the clock edge.
        reset = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 0, 0);
        #1;
        check("por rd_ready1", 32'(rd_ready1), 32'd1);
        check("por busy_vec", 32'(busy_vec), 32'h0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven per-cycle vectors on the 16-register instance.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].ir, vecs[i].wv, vecs[i].wr, vecs[i].wd,
                  vecs[i].a1, vecs[i].a2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d rd_data1", i),  32'(rd_data1),  32'(vecs[i].d1));
            check($sformatf("v%0d rd_ready1", i), 32'(rd_ready1), 32'(vecs[i].r1));
            check($sformatf("v%0d rd_data2", i),  32'(rd_data2),  32'(vecs[i].d2));
            check($sformatf("v%0d rd_ready2", i), 32'(rd_ready2), 32'(vecs[i].r2));
            check($sformatf("v%0d busy_vec", i),  32'(busy_vec),  32'(vecs[i].busy));
            check($sformatf("v%0d last_wb", i),   32'(last_wb),   32'(vecs[i].lwb));
        end

        // NUM_REGS=8 instance: reg 12 was never written, reads as 0 / ready.
        drive(0, 0, 0, 0, 16'h0, 12, 3);
        @(posedge clk);
        #1;
        check("n8 rd_data1 reg12",  32'(rd_data1_8),  32'h0);
        check("n8 rd_ready1 reg12", 32'(rd_ready1_8), 32'd1);
        check("n8 rd_data2 reg3",   32'(rd_data2_8),  32'hBEEF);
        check("n8 busy_vec",        32'(busy_vec_8),  32'h0);
        check("n8 last_wb",         32'(last_wb_8),   32'h4444);
        check("n16 rd_data1 reg12", 32'(rd_data1),    32'hCAFE);

        // Build up more busy state, then assert reset mid-cycle with an
        // issue and a write-back in flight.
        drive(1, 6, 0, 0, 16'h0, 12, 3);
        @(posedge clk);
        #1;
        check("pre-reset busy_vec", 32'(busy_vec), 32'h0240);
        drive(1, 8, 1, 3, 16'h1111, 12, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async rd_data1",  32'(rd_data1),   32'h0);
        check("async rd_data2",  32'(rd_data2),   32'h0);
        check("async rd_ready1", 32'(rd_ready1),  32'd1);
        check("async rd_ready2", 32'(rd_ready2),  32'd1);
        check("async busy_vec",  32'(busy_vec),   32'h0);
        check("async last_wb",   32'(last_wb),    32'h0);
        check("async n8 data2",  32'(rd_data2_8), 32'h0);
        @(posedge clk);
        #1;
        check("reset-cycle busy_vec", 32'(busy_vec), 32'h0);
        check("reset-cycle last_wb",  32'(last_wb),  32'h0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 3, 6);
        @(posedge clk);
        #1;
        check("post-reset reg3",     32'(rd_data1),  32'h0);
        check("post-reset ready reg6", 32'(rd_ready2), 32'd1);
        check("post-reset busy_vec", 32'(busy_vec),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
